// File: rtl/cpu_defs.sv
// Shared encodings for the multicycle MIPS-subset control path: states, opcodes, functs, mux codes.
// Pure definitions; no timing or flow control of its own.
package cpu_defs;

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLTZ  = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] HALT_OP  = 6'b111111;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_JR  = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_RS  = 2'b10;
  localparam logic [1:0] PCSRC_JMP = 2'b11;

  localparam logic [1:0] REGDST_RA = 2'b00;
  localparam logic [1:0] REGDST_RT = 2'b01;
  localparam logic [1:0] REGDST_RD = 2'b10;

  typedef struct packed {
    logic       valid;
    logic       isImm;
    logic [2:0] aluOp;
  } aluDec_t;

  // Register-writing ALU instructions; anything unrecognised comes back invalid and runs as a NOP.
  function automatic aluDec_t decodeAlu(input logic [5:0] opcode, input logic [5:0] funct);
    aluDec_t d;
    d = '{valid: 1'b0, isImm: 1'b0, aluOp: ALU_ADD};
    case (opcode)
      OP_RTYPE: begin
        d.valid = 1'b1;
        case (funct)
          F_ADD:   d.aluOp = ALU_ADD;
          F_SUB:   d.aluOp = ALU_SUB;
          F_AND:   d.aluOp = ALU_AND;
          F_OR:    d.aluOp = ALU_OR;
          F_SLT:   d.aluOp = ALU_SLT;
          F_SLL:   d.aluOp = ALU_SLL;
          default: d.valid = 1'b0;
        endcase
      end
      OP_ADDIU: d = '{valid: 1'b1, isImm: 1'b1, aluOp: ALU_ADD};
      OP_ANDI:  d = '{valid: 1'b1, isImm: 1'b1, aluOp: ALU_AND};
      OP_ORI:   d = '{valid: 1'b1, isImm: 1'b1, aluOp: ALU_OR};
      OP_SLTI:  d = '{valid: 1'b1, isImm: 1'b1, aluOp: ALU_SLT};
      default:  d = '{valid: 1'b0, isImm: 1'b0, aluOp: ALU_ADD};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational control-word decoder: outputs follow state/opcode/funct/flags in the same cycle.
// No backpressure; enables are forced low while Reset is held low.
module control_decode
  import cpu_defs::*;
(
  input  state_t     state,
  input  logic       Reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       sign,
  output logic       PCWre,
  output logic       IRWre,
  output logic       InsMemRW,
  output logic       RegWre,
  output logic [1:0] RegDst,
  output logic       WrRegDSrc,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       ExtSel,
  output logic       mRD,
  output logic       mWR,
  output logic       DBDataSrc,
  output logic [1:0] PCSrc
);

  aluDec_t aluInfo;
  logic    pcWreRaw;
  logic    irWreRaw;
  logic    regWreRaw;
  logic    mRdRaw;
  logic    mWrRaw;
  logic    isJr;
  logic    isSll;
  logic    brTaken;

  assign aluInfo  = decodeAlu(opcode, funct);
  assign isJr     = (opcode == OP_RTYPE) && (funct == F_JR);
  assign isSll    = (opcode == OP_RTYPE) && (funct == F_SLL);
  assign InsMemRW = 1'b1;

  always_comb begin
    case (opcode)
      OP_BEQ:  brTaken = zero;
      OP_BNE:  brTaken = !zero;
      OP_BLTZ: brTaken = sign;
      default: brTaken = 1'b0;
    endcase
  end

  always_comb begin
    pcWreRaw  = 1'b0;
    irWreRaw  = 1'b0;
    regWreRaw = 1'b0;
    mRdRaw    = 1'b0;
    mWrRaw    = 1'b0;
    RegDst    = REGDST_RA;
    WrRegDSrc = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ALUOp     = ALU_ADD;
    ExtSel    = 1'b0;
    DBDataSrc = 1'b0;
    PCSrc     = PCSRC_SEQ;
    case (state)
      S_IF: irWreRaw = 1'b1;
      S_ID: begin
        if (opcode == OP_J) begin
          pcWreRaw = 1'b1;
          PCSrc    = PCSRC_JMP;
        end else if (opcode == OP_JAL) begin
          pcWreRaw  = 1'b1;
          PCSrc     = PCSRC_JMP;
          regWreRaw = 1'b1;
          RegDst    = REGDST_RA;
          WrRegDSrc = 1'b0;
        end else if (isJr) begin
          pcWreRaw = 1'b1;
          PCSrc    = PCSRC_RS;
        end
      end
      S_EXE_AL, S_WB_AL: begin
        if (aluInfo.valid) begin
          ALUSrcB = aluInfo.isImm;
          ALUSrcA = isSll;
          ExtSel  = (opcode == OP_ADDIU) || (opcode == OP_SLTI);
          ALUOp   = aluInfo.aluOp;
          if (state == S_WB_AL) begin
            regWreRaw = 1'b1;
            WrRegDSrc = 1'b1;
            RegDst    = aluInfo.isImm ? REGDST_RT : REGDST_RD;
          end
        end
        // A NOP still has to retire, so the PC advances even without a write.
        if (state == S_WB_AL) pcWreRaw = 1'b1;
      end
      S_EXE_BR: begin
        pcWreRaw = 1'b1;
        ExtSel   = 1'b1;
        ALUOp    = (opcode == OP_BLTZ) ? ALU_ADD : ALU_SUB;
        PCSrc    = brTaken ? PCSRC_BR : PCSRC_SEQ;
      end
      S_EXE_LS: begin
        ALUSrcB = 1'b1;
        ExtSel  = 1'b1;
        ALUOp   = ALU_ADD;
      end
      S_MEM: begin
        if (opcode == OP_LW) begin
          mRdRaw = 1'b1;
        end else if (opcode == OP_SW) begin
          mWrRaw   = 1'b1;
          pcWreRaw = 1'b1;
        end
      end
      S_WB_LD: begin
        mRdRaw    = 1'b1;
        DBDataSrc = 1'b1;
        WrRegDSrc = 1'b1;
        RegDst    = REGDST_RT;
        regWreRaw = 1'b1;
        pcWreRaw  = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset gating keeps an aborted instruction from touching PC, IR, registers or memory.
  assign PCWre  = pcWreRaw  & Reset;
  assign IRWre  = irWreRaw  & Reset;
  assign RegWre = regWreRaw & Reset;
  assign mRD    = mRdRaw    & Reset;
  assign mWR    = mWrRaw    & Reset;

endmodule

// File: rtl/multicycle_control_unit.sv
// Five-phase multicycle CPU controller: state register plus next-state logic; 2-5 cycles per instruction.
// No backpressure; HALT_OP parks the machine in ID until Reset is pulled low.
module multicycle_control_unit
  import cpu_defs::*;
(
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       sign,
  output logic       PCWre,
  output logic       IRWre,
  output logic       InsMemRW,
  output logic       RegWre,
  output logic [1:0] RegDst,
  output logic       WrRegDSrc,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       ExtSel,
  output logic       mRD,
  output logic       mWR,
  output logic       DBDataSrc,
  output logic [1:0] PCSrc,
  output logic [2:0] state
);

  state_t curState;
  state_t nextState;
  logic   isJr;

  assign isJr  = (opcode == OP_RTYPE) && (funct == F_JR);
  assign state = curState;

  always_comb begin
    nextState = S_IF;
    case (curState)
      S_IF: nextState = S_ID;
      S_ID: begin
        if ((opcode == OP_J) || (opcode == OP_JAL) || isJr)
          nextState = S_IF;
        else if (opcode == HALT_OP)
          nextState = S_ID;
        else if ((opcode == OP_BEQ) || (opcode == OP_BNE) || (opcode == OP_BLTZ))
          nextState = S_EXE_BR;
        else if ((opcode == OP_LW) || (opcode == OP_SW))
          nextState = S_EXE_LS;
        else
          nextState = S_EXE_AL;
      end
      S_EXE_AL: nextState = S_WB_AL;
      S_WB_AL:  nextState = S_IF;
      S_EXE_BR: nextState = S_IF;
      S_EXE_LS: nextState = S_MEM;
      S_MEM:    nextState = (opcode == OP_LW) ? S_WB_LD : S_IF;
      S_WB_LD:  nextState = S_IF;
      default:  nextState = S_IF;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset) curState <= S_IF;
    else        curState <= nextState;
  end

  control_decode uDecode (
    .state     (curState),
    .Reset     (Reset),
    .opcode    (opcode),
    .funct     (funct),
    .zero      (zero),
    .sign      (sign),
    .PCWre     (PCWre),
    .IRWre     (IRWre),
    .InsMemRW  (InsMemRW),
    .RegWre    (RegWre),
    .RegDst    (RegDst),
    .WrRegDSrc (WrRegDSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .ExtSel    (ExtSel),
    .mRD       (mRD),
    .mWR       (mWR),
    .DBDataSrc (DBDataSrc),
    .PCSrc     (PCSrc)
  );

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: an instruction-level model predicts every cycle's control word.
module tb_multicycle_control_unit;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       sign;
  logic       PCWre, IRWre, InsMemRW, RegWre, WrRegDSrc, ALUSrcA, ALUSrcB;
  logic       ExtSel, mRD, mWR, DBDataSrc;
  logic [1:0] RegDst, PCSrc;
  logic [2:0] ALUOp, state;

  multicycle_control_unit dut (
    .CLK(CLK), .Reset(Reset), .opcode(opcode), .funct(funct), .zero(zero), .sign(sign),
    .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .RegWre(RegWre), .RegDst(RegDst),
    .WrRegDSrc(WrRegDSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .ExtSel(ExtSel), .mRD(mRD), .mWR(mWR), .DBDataSrc(DBDataSrc), .PCSrc(PCSrc), .state(state)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [2:0] st;
    logic       pcWre, irWre, insMemRW, regWre;
    logic [1:0] regDst;
    logic       wrRegDSrc, aluSrcA, aluSrcB;
    logic [2:0] aluOp;
    logic       extSel, mRD, mWR, dbDataSrc;
    logic [1:0] pcSrc;
  } ctl_t;

  typedef enum int {K_ALU_R, K_ALU_I, K_NOP, K_LW, K_SW, K_BR, K_J, K_JR, K_JAL, K_HALT} kind_t;

  ctl_t  act;
  ctl_t  expQ[$];
  ctl_t  expCur;
  string curTag = "reset";
  int    vectors = 0;
  int    miscompares = 0;

  assign act = {state, PCWre, IRWre, InsMemRW, RegWre, RegDst, WrRegDSrc, ALUSrcA, ALUSrcB,
                ALUOp, ExtSel, mRD, mWR, DBDataSrc, PCSrc};

  function automatic kind_t kindOf(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'd0: begin
        if (fn == 6'b001000) return K_JR;
        if (fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 || fn == 6'b100101 ||
            fn == 6'b101010 || fn == 6'b000000) return K_ALU_R;
        return K_NOP;
      end
      6'b001001, 6'b001100, 6'b001101, 6'b001010: return K_ALU_I;
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000100, 6'b000101, 6'b000001: return K_BR;
      6'b000010: return K_J;
      6'b000011: return K_JAL;
      6'b111111: return K_HALT;
      default:   return K_NOP;
    endcase
  endfunction

  function automatic int cyclesOf(input kind_t k);
    case (k)
      K_J, K_JR, K_JAL: return 2;
      K_BR:             return 3;
      K_LW:             return 5;
      K_HALT:           return 1000;
      default:          return 4;
    endcase
  endfunction

  // ALU operation named by the instruction: add/addiu, sub, sll, or/ori, and/andi, slt/slti.
  function automatic logic [2:0] aluOf(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'b001001 || (op == 0 && fn == 6'b100000)) return 3'd0;
    if (op == 0 && fn == 6'b100010) return 3'd1;
    if (op == 0 && fn == 6'b000000) return 3'd2;
    if (op == 6'b001101 || (op == 0 && fn == 6'b100101)) return 3'd3;
    if (op == 6'b001100 || (op == 0 && fn == 6'b100100)) return 3'd4;
    return 3'd5;
  endfunction

  // Expected control word at cycle 'step' (0 = fetch) of the given instruction.
  function automatic ctl_t expFor(input logic [5:0] op, input logic [5:0] fn, input logic z,
                                  input logic s, input int step, input logic rstLow);
    kind_t k = kindOf(op, fn);
    int    n = cyclesOf(k);
    ctl_t  e = '0;
    logic  taken;
    e.insMemRW = 1'b1;
    if (step == 0)      e.st = 3'b000;
    else if (step == 1) e.st = 3'b001;
    else if (step == 2) e.st = (k == K_BR) ? 3'b101 : (k == K_LW || k == K_SW) ? 3'b010 : 3'b110;
    else if (step == 3) e.st = (k == K_LW || k == K_SW) ? 3'b011 : 3'b111;
    else                e.st = 3'b100;
    if (k == K_HALT && step >= 1) e.st = 3'b001;
    e.irWre = (step == 0);
    e.pcWre = (k != K_HALT) && (step == n - 1);
    case (k)
      K_ALU_R, K_ALU_I: if (step >= 2) begin
        e.aluOp   = aluOf(op, fn);
        e.aluSrcB = (k == K_ALU_I);
        e.aluSrcA = (op == 0 && fn == 0);
        e.extSel  = (op == 6'b001001 || op == 6'b001010);
        if (step == 3) begin
          e.regWre    = 1'b1;
          e.wrRegDSrc = 1'b1;
          e.regDst    = (k == K_ALU_I) ? 2'b01 : 2'b10;
        end
      end
      K_LW, K_SW: begin
        if (step == 2) begin
          e.aluSrcB = 1'b1;
          e.extSel  = 1'b1;
        end
        if (step == 3) begin
          e.mRD = (k == K_LW);
          e.mWR = (k == K_SW);
        end
        if (step == 4) begin
          e.mRD = 1'b1; e.dbDataSrc = 1'b1; e.wrRegDSrc = 1'b1; e.regDst = 2'b01; e.regWre = 1'b1;
        end
      end
      K_BR: if (step == 2) begin
        e.extSel = 1'b1;
        e.aluOp  = (op == 6'b000001) ? 3'd0 : 3'd1;
        taken    = (op == 6'b000100) ? z : (op == 6'b000101) ? !z : s;
        e.pcSrc  = taken ? 2'b01 : 2'b00;
      end
      K_J:   if (step == 1) e.pcSrc = 2'b11;
      K_JR:  if (step == 1) e.pcSrc = 2'b10;
      K_JAL: if (step == 1) begin
        e.pcSrc  = 2'b11;
        e.regWre = 1'b1;
      end
      default: ;
    endcase
    if (rstLow) begin
      e.pcWre = 0; e.irWre = 0; e.regWre = 0; e.mRD = 0; e.mWR = 0;
    end
    return e;
  endfunction

  always @(negedge CLK) begin
    if (expQ.size() > 0) begin
      expCur = expQ.pop_front();
      vectors++;
      if (act !== expCur) begin
        miscompares++;
        $display("FAIL %s: control word got %b required %b (state got %b required %b)",
                 curTag, act, expCur, act.st, expCur.st);
      end
    end
  end

  task automatic lit(input string name, input logic [7:0] actual, input logic [7:0] required);
    vectors++;
    if (actual !== required) begin
      miscompares++;
      $display("FAIL %s: got %0d required %0d", name, actual, required);
    end
  endtask

  bit firstAfterReset = 1'b0;

  task automatic runInstr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                          input logic z, input logic s, input int abortAt, input int litPc);
    kind_t k = kindOf(op, fn);
    int    n = (abortAt >= 0) ? abortAt + 1 : cyclesOf(k);
    logic  zz, ss, rst;
    for (int step = 0; step < n; step++) begin
      zz  = (k == K_BR && step == 2) ? z : 1'($urandom_range(0, 1));
      ss  = (k == K_BR && step == 2) ? s : 1'($urandom_range(0, 1));
      rst = (step == abortAt) ? 1'b0 : 1'b1;
      opcode = op; funct = fn; zero = zz; sign = ss; Reset = rst;
      curTag = $sformatf("%s_step%0d", tag, step);
      expQ.push_back(expFor(op, fn, zz, ss, step, !rst));
      @(negedge CLK); #1;
      if (firstAfterReset && step == 0) begin
        lit("first_if_state", 8'(state), 8'd0);
        lit("first_if_irwre", 8'(IRWre), 8'd1);
        firstAfterReset = 1'b0;
      end
      if (litPc >= 0 && k == K_BR && step == 2) lit({tag, "_pcsrc"}, 8'(PCSrc), 8'(litPc));
      if (k == K_JAL && step == 1) begin
        lit("jal_regwre", 8'(RegWre), 8'd1);
        lit("jal_regdst", 8'(RegDst), 8'd0);
        lit("jal_wrsrc", 8'(WrRegDSrc), 8'd0);
        lit("jal_pcsrc", 8'(PCSrc), 8'd3);
        lit("jal_pcwre", 8'(PCWre), 8'd1);
      end
      if (op == 6'b001001 && step == 3 && abortAt < 0) begin
        lit("addiu_state", 8'(state), 8'd7);
        lit("addiu_regwre", 8'(RegWre), 8'd1);
        lit("addiu_regdst", 8'(RegDst), 8'd1);
        lit("addiu_extsel", 8'(ExtSel), 8'd1);
        lit("addiu_alusrcb", 8'(ALUSrcB), 8'd1);
      end
      if (k == K_LW && step == 4) begin
        lit("lw_dbsrc", 8'(DBDataSrc), 8'd1);
        lit("lw_regwre", 8'(RegWre), 8'd1);
      end
      if (k == K_SW && step == 3) lit("sw_mwr", 8'(mWR), 8'd1);
      if (k == K_HALT && step == 11) begin
        lit("halt_state", 8'(state), 8'd1);
        lit("halt_pcwre", 8'(PCWre), 8'd0);
        lit("halt_irwre", 8'(IRWre), 8'd0);
      end
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    Reset = 1'b0; opcode = '0; funct = '0; zero = 1'b0; sign = 1'b0;
    @(posedge CLK); #1;
    // Second reset cycle: state already IF, all enables held low.
    curTag = "reset_hold";
    expQ.push_back(expFor(6'd0, 6'd0, 1'b0, 1'b0, 0, 1'b1));
    @(negedge CLK); #1;
    lit("reset_state", 8'(state), 8'd0);
    lit("reset_regwre", 8'(RegWre), 8'd0);
    lit("reset_pcwre", 8'(PCWre), 8'd0);
    @(posedge CLK); #1;
    firstAfterReset = 1'b1;

    runInstr("addiu", 6'b001001, 6'b100010, 0, 0, -1, -1);
    runInstr("add",   6'b000000, 6'b100000, 0, 0, -1, -1);
    runInstr("sub",   6'b000000, 6'b100010, 0, 0, -1, -1);
    runInstr("and",   6'b000000, 6'b100100, 0, 0, -1, -1);
    runInstr("or",    6'b000000, 6'b100101, 0, 0, -1, -1);
    runInstr("slt",   6'b000000, 6'b101010, 0, 0, -1, -1);
    runInstr("sll",   6'b000000, 6'b000000, 0, 0, -1, -1);
    runInstr("andi",  6'b001100, 6'b101010, 0, 0, -1, -1);
    runInstr("ori",   6'b001101, 6'b000000, 0, 0, -1, -1);
    runInstr("slti",  6'b001010, 6'b001000, 0, 0, -1, -1);
    runInstr("lw",    6'b100011, 6'b000000, 0, 0, -1, -1);
    runInstr("sw",    6'b101011, 6'b000000, 0, 0, -1, -1);
    runInstr("beq_z1",  6'b000100, 6'b000000, 1, 0, -1, 1);
    runInstr("beq_z0",  6'b000100, 6'b000000, 0, 1, -1, 0);
    runInstr("bne_z0",  6'b000101, 6'b000000, 0, 0, -1, 1);
    runInstr("bne_z1",  6'b000101, 6'b000000, 1, 1, -1, 0);
    runInstr("bltz_s1", 6'b000001, 6'b000000, 1, 1, -1, 1);
    runInstr("bltz_s0", 6'b000001, 6'b000000, 0, 0, -1, 0);
    runInstr("j",     6'b000010, 6'b000000, 0, 0, -1, -1);
    runInstr("jr",    6'b000000, 6'b001000, 0, 0, -1, -1);
    runInstr("jal",   6'b000011, 6'b000000, 0, 0, -1, -1);
    runInstr("nop_funct",  6'b000000, 6'b111111, 0, 0, -1, -1);
    runInstr("nop_opcode", 6'b010000, 6'b000000, 0, 0, -1, -1);
    runInstr("lw_abort_mem",   6'b100011, 6'b000000, 0, 0, 3, -1);
    runInstr("addiu_abort_wb", 6'b001001, 6'b000000, 0, 0, 3, -1);
    runInstr("sw_abort_exe",   6'b101011, 6'b000000, 0, 0, 2, -1);
    runInstr("halt",  6'b111111, 6'b000000, 0, 0, 12, -1);
    runInstr("after_halt", 6'b001001, 6'b000000, 0, 0, -1, -1);
    runInstr("jal2",  6'b000011, 6'b000000, 0, 0, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before the sequence completed");
    $fatal(1, "watchdog");
  end

endmodule
